// File: rtl/pipeline_pkg.sv
// Shared pipeline constants and the fetch-unit state encoding.
package pipeline_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        FETCH = 1'b0,
        DROP  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry {pc,instr} FIFO between instruction memory and decode.
module fetch_queue (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  logic [31:0] push_pc,
    input  logic [31:0] push_instr,
    output logic [1:0]  count,
    output logic        empty,
    output logic [31:0] head_pc,
    output logic [31:0] head_instr
);

    logic [31:0] pc_mem    [2];
    logic [31:0] instr_mem [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic        do_push;
    logic        do_pop;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            if (do_push && !do_pop)
                count <= count + 2'd1;
            else if (do_pop && !do_push)
                count <= count - 2'd1;
        end
    end

    // Storage needs no reset; the head is qualified by count.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            pc_mem[wr_ptr]    <= push_pc;
            instr_mem[wr_ptr] <= push_instr;
        end
    end

    assign empty      = (count == 2'd0);
    assign head_pc    = pc_mem[rd_ptr];
    assign head_instr = instr_mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, memory request handshake, 2-entry queue to decode.
// Optional FETCH_NOP_FILL_EN drives a NOP on Do_instr while the queue is empty.
//
//   state | meaning
//   FETCH | normal fetching; new requests issue while queue has room
//   DROP  | redirect hit a pending request; wait for its ack and discard data
module fetch_unit
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset_x,
    output logic        Fo_imemReq,
    output logic [31:0] Fo_imemAddr,
    input  logic        Fi_imemAck,
    input  logic [31:0] Fi_imemRdata,
    input  logic        Fi_stall,
    input  logic        Fi_redirect,
    input  logic [31:0] Fi_redirectPC,
    output logic        Do_valid,
    output logic [31:0] Do_instr,
    output logic [31:0] Do_pc
);

    localparam logic [1:0] QMAX = 2'(QDEPTH);

`ifdef FETCH_NOP_FILL_EN
    localparam logic [31:0] EMPTY_INSTR = NOP_INSTR;
`else
    localparam logic [31:0] EMPTY_INSTR = 32'h0000_0000;
`endif

    fetch_state_t state_q;
    fetch_state_t state_d;
    logic [31:0]  pc_q;
    logic         pend_q;
    logic [31:0]  pend_addr_q;
    logic [1:0]   q_count;
    logic         q_empty;
    logic [31:0]  head_pc;
    logic [31:0]  head_instr;
    logic         done;
    logic         push;
    logic         pop;
    logic [31:0]  target;

    assign done   = Fo_imemReq && Fi_imemAck;
    assign push   = done && (state_q == FETCH) && !Fi_redirect;
    assign pop    = !q_empty && !Fi_stall && !Fi_redirect;
    assign target = Fi_redirectPC & 32'hFFFF_FFFC;

    always_ff @(posedge clk or posedge reset_x) begin
        if (reset_x)
            state_q <= FETCH;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH: if (Fi_redirect && Fo_imemReq && !Fi_imemAck) state_d = DROP;
            DROP:  if (done) state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    // Reset gates the request combinationally so it withdraws immediately.
    always_comb begin
        Fo_imemReq  = !reset_x &&
                      (pend_q || ((state_q == FETCH) && (q_count < QMAX)));
        Fo_imemAddr = pend_q ? pend_addr_q : pc_q;
        Do_valid    = !q_empty;
        Do_pc       = q_empty ? 32'h0000_0000 : head_pc;
        Do_instr    = q_empty ? EMPTY_INSTR : head_instr;
    end

    always_ff @(posedge clk or posedge reset_x) begin
        if (reset_x) begin
            pc_q        <= RESET_PC;
            pend_q      <= 1'b0;
            pend_addr_q <= 32'h0000_0000;
        end else begin
            if (Fi_redirect)
                pc_q <= target;
            else if (push)
                pc_q <= pc_q + 32'd4;
            pend_q      <= Fo_imemReq && !Fi_imemAck;
            pend_addr_q <= Fo_imemAddr;
        end
    end

    fetch_queue u_queue (
        .clk        (clk),
        .rst        (reset_x),
        .push       (push),
        .pop        (pop),
        .flush      (Fi_redirect),
        .push_pc    (Fo_imemAddr),
        .push_instr (Fi_imemRdata),
        .count      (q_count),
        .empty      (q_empty),
        .head_pc    (head_pc),
        .head_instr (head_instr)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a scoreboard of expected decode outputs.
module tb_fetch_unit;
    import pipeline_pkg::*;

`ifdef FETCH_NOP_FILL_EN
    localparam logic [31:0] EMPTY = 32'h0000_0013;
`else
    localparam logic [31:0] EMPTY = 32'h0000_0000;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset_x = 1'b1;
    logic        ack = 1'b0;
    logic        stall = 1'b0;
    logic        redir = 1'b0;
    logic [31:0] rpc = 32'h0;
    logic        req;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;

    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_rdata;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [31:0] w_pc;

    int   checks = 0;
    int   errors = 0;
    ent_t sb[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign rdata   = mem_word(addr);
    assign w_rdata = mem_word(w_addr);

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .reset_x(reset_x),
        .Fo_imemReq(req), .Fo_imemAddr(addr),
        .Fi_imemAck(ack), .Fi_imemRdata(rdata),
        .Fi_stall(stall), .Fi_redirect(redir), .Fi_redirectPC(rpc),
        .Do_valid(valid), .Do_instr(instr), .Do_pc(pc)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .reset_x(reset_x),
        .Fo_imemReq(w_req), .Fo_imemAddr(w_addr),
        .Fi_imemAck(1'b1), .Fi_imemRdata(w_rdata),
        .Fi_stall(1'b0), .Fi_redirect(1'b0), .Fi_redirectPC(32'h0),
        .Do_valid(w_valid), .Do_instr(w_instr), .Do_pc(w_pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: compare decode outputs to the scoreboard, then
    // drive inputs for the next rising edge and record what it should push.
    task automatic cyc(input logic a, input logic s, input logic r,
                       input logic [31:0] target, input bit keep);
        ent_t e;
        if (sb.size() > 0) begin
            chk("do_valid", 32'(valid), 32'd1);
            chk("do_pc", pc, sb[0].pc);
            chk("do_instr", instr, sb[0].instr);
            if (!s && !r) void'(sb.pop_front());
        end else begin
            chk("do_valid_empty", 32'(valid), 32'd0);
            chk("do_pc_empty", pc, 32'h0);
            chk("do_instr_empty", instr, EMPTY);
        end
        ack   = a;
        stall = s;
        redir = r;
        rpc   = target;
        if (r) sb.delete();
        if (req && a && keep && !r) begin
            e.pc    = addr;
            e.instr = mem_word(addr);
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_x = 1'b1;
        ack = 1'b0; stall = 1'b0; redir = 1'b0; rpc = 32'h0;
        sb.delete();
        @(negedge clk);
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, EMPTY);
        @(negedge clk);
        reset_x = 1'b0;
        #1;
        chk("first_req", 32'(req), 32'd1);
        chk("first_addr", addr, 32'h0);
        chk("wrap_first_addr", w_addr, 32'hFFFF_FFFC);
    endtask

    initial begin
        // Streaming with ack tied high; also checks RESET_PC wrap on u_wrap.
        do_reset();
        chk("stream_addr0", addr, 32'h0);
        cyc(1, 0, 0, 0, 1);
        chk("stream_addr4", addr, 32'h4);
        chk("wrap_second_addr", w_addr, 32'h0);
        cyc(1, 0, 0, 0, 1);
        chk("stream_addr8", addr, 32'h8);
        cyc(1, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);

        // Stall fills the queue, request drops, then drains with no gap.
        do_reset();
        cyc(1, 1, 0, 0, 1);
        cyc(1, 1, 0, 0, 1);
        chk("stall_req_off", 32'(req), 32'd0);
        cyc(1, 1, 0, 0, 1);
        chk("stall_req_off2", 32'(req), 32'd0);
        cyc(1, 1, 0, 0, 1);
        chk("drain_pc0", pc, 32'h0);
        cyc(1, 0, 0, 0, 1);
        chk("drain_pc4", pc, 32'h4);
        chk("drain_addr8", addr, 32'h8);
        cyc(1, 0, 0, 0, 1);
        chk("drain_pc8", pc, 32'h8);
        cyc(0, 0, 0, 0, 1);

        // Delayed ack on addr 8 with redirect while pending: data dropped.
        do_reset();
        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);
        chk("hold_addr_c2", addr, 32'h8);
        cyc(0, 1, 0, 0, 1);
        chk("hold_addr_c3", addr, 32'h8);
        cyc(0, 0, 1, 32'h100, 0);
        chk("hold_addr_c4", addr, 32'h8);
        chk("hold_req_c4", 32'(req), 32'd1);
        cyc(0, 0, 0, 0, 0);
        chk("hold_addr_c5", addr, 32'h8);
        cyc(1, 0, 0, 0, 0);
        chk("redir_addr", addr, 32'h100);
        cyc(1, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);

        // Second redirect while in DROP overwrites the target.
        do_reset();
        cyc(0, 0, 1, 32'h40, 0);
        chk("drop_hold_addr", addr, 32'h0);
        cyc(0, 0, 1, 32'h80, 0);
        chk("drop_hold_addr2", addr, 32'h0);
        cyc(1, 0, 0, 0, 0);
        chk("drop_new_addr", addr, 32'h80);
        cyc(1, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);

        // Redirect coincident with ack: data discarded, target aligned.
        do_reset();
        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 1, 32'h203, 0);
        chk("coinc_addr", addr, 32'h200);
        chk("coinc_req", 32'(req), 32'd1);
        cyc(1, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);

        // Asynchronous reset while a request is pending.
        do_reset();
        cyc(1, 1, 0, 0, 1);
        cyc(0, 1, 0, 0, 1);
        chk("pre_rst_req", 32'(req), 32'd1);
        chk("pre_rst_valid", 32'(valid), 32'd1);
        #2;
        reset_x = 1'b1;
        #1;
        chk("async_rst_req", 32'(req), 32'd0);
        chk("async_rst_valid", 32'(valid), 32'd0);
        chk("async_rst_pc", pc, 32'h0);
        chk("async_rst_instr", instr, EMPTY);
        sb.delete();
        ack = 1'b0; stall = 1'b0;
        @(negedge clk);
        reset_x = 1'b0;
        #1;
        chk("restart_req", 32'(req), 32'd1);
        chk("restart_addr", addr, 32'h0);
        cyc(1, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC fetched first after reset.
REQ-002 SHALL have parameter QDEPTH, default 2, fixed at 2 entries (other values unsupported).
REQ-003 SHALL have one clock and an asynchronous, active-high reset. The clock port is clk and the reset port is reset_x.
REQ-004 SHALL have: clk  in  1  rising-edge clock.
REQ-005 SHALL have: reset_x  in  1  async active-high reset.
REQ-006 SHALL have: Fo_imemReq  out  1  instruction-memory request.
REQ-007 SHALL have: Fo_imemAddr  out  32  request address, word aligned.
REQ-008 SHALL have: Fi_imemAck  in  1  request accepted, data valid this cycle.
REQ-009 SHALL have: Fi_imemRdata  in  32  instruction word, valid when Fi_imemAck=1.
REQ-010 SHALL have: Fi_stall  in  1  hazard-unit fetch stall; decode holds its instruction.
REQ-011 SHALL have: Fi_redirect  in  1  flush plus PC redirect (taken branch, jal, jalr, ecall, mret).
REQ-012 SHALL have: Fi_redirectPC  in  32  redirect target.
REQ-013 SHALL have: Do_valid  out  1  Do_instr/Do_pc hold a real instruction.
REQ-014 SHALL have: Do_instr  out  32  instruction to decode.
REQ-015 SHALL have: Do_pc  out  32  PC of Do_instr.

Function
REQ-016 SHALL hold a fetch PC register and a 2-entry {pc,instr} FIFO; Do_* SHALL be driven from the FIFO head combinationally; Do_valid = FIFO non-empty.
REQ-017 SHALL complete a memory transaction on any rising edge with Fo_imemReq=1 and Fi_imemAck=1; at most one transaction outstanding.
REQ-018 Once Fo_imemReq is asserted, Fo_imemReq and Fo_imemAddr SHALL stay stable until the ack, regardless of stall, redirect or FIFO level.
REQ-019 SHALL assert a new request only in state FETCH with FIFO count < 2; Fo_imemAddr = fetch PC.
REQ-020 On a completed transaction in FETCH, SHALL push {Fo_imemAddr, Fi_imemRdata} and set PC = PC + 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
REQ-021 Pop SHALL occur when Do_valid=1 and Fi_stall=0; a simultaneous push and pop SHALL leave the count unchanged.
REQ-022 Fi_stall=1 SHALL freeze the FIFO head only; outstanding and new requests proceed while count < 2.
REQ-023 Fi_redirect SHALL take priority over Fi_stall and push: FIFO emptied (Do_valid=0 next cycle), PC = {Fi_redirectPC[31:2],2'b00}.
REQ-024 States SHALL be FETCH and DROP. FETCH->DROP when a redirect arrives with a request asserted but not acked. DROP->FETCH on that ack, with the returned data discarded.
REQ-025 In DROP, a further redirect SHALL overwrite the PC target and remain in DROP.
REQ-026 A redirect in the same cycle as an ack SHALL discard that data and stay in FETCH; the next request uses the target.
REQ-027 Latency: with the FIFO empty and ack in the request cycle, the instruction SHALL appear on Do_* the cycle after the ack.

Reset
REQ-028 On reset_x=1, asynchronously: FIFO empty, Do_valid=0, Fo_imemReq=0, state=FETCH, PC=RESET_PC; Do_pc=0, Do_instr per REQ-031/032.
REQ-029 Fo_imemReq SHALL assert with Fo_imemAddr=RESET_PC in the first cycle after reset release.
REQ-030 Reset mid-transaction SHALL abandon it; the memory side treats reset as request withdrawal.

Configuration
REQ-031 With FETCH_NOP_FILL_EN defined: when Do_valid=0, Do_instr SHALL be 32'h0000_0013 (addi x0,x0,0).
REQ-032 Without FETCH_NOP_FILL_EN: when Do_valid=0, Do_instr SHALL be 32'h0000_0000; decode qualifies with Do_valid.

Structure
REQ-033 Package pipeline_pkg SHALL hold the NOP constant, the FETCH/DROP state encoding and the default RESET_PC.
REQ-034 The FIFO SHALL be sub-module fetch_queue (2 entries, push/pop/flush, count, head outputs).

Verification
REQ-035 Reset, ack tied 1, no stall: addresses 0,4,8 issued on consecutive cycles; Do_pc 0,4,8 one cycle after each ack.
REQ-036 Fi_stall=1 for 4 cycles with ack=1: FIFO fills to 2, Fo_imemReq drops; Do_pc holds 0; on release Do_pc 0->4->8 with no gap.
REQ-037 Ack delayed 3 cycles on addr 8, redirect to 32'h100 in cycle 1: Fo_imemAddr stays 8 until ack; data dropped; next request 32'h100; Do_valid=0 meanwhile.
REQ-038 Redirect to 32'h203 coincident with ack: data discarded; next Fo_imemAddr=32'h200.
REQ-039 RESET_PC=32'hFFFF_FFFC: second request address is 32'h0000_0000.
REQ-040 Reset asserted while a request is pending: Fo_imemReq=0 and Do_valid=0 immediately; restart at RESET_PC; with FETCH_NOP_FILL_EN, Do_instr=32'h0000_0013 while empty.
